// File: rtl/toy_run_ctrl.sv
// toy_run_ctrl: run/step/stop sequencer and data-memory arbiter for the TOY core.
//
// Ports:
//   clk_i, rst_i                    clock, asynchronous active-high reset
//   run_i, stop_i, step_i           front-panel control pulses
//   load_pc_i, pc_sw_i              front-panel PC load pulse and switches
//   halt_i, instr_val_i             core HLT pulse, instruction-fetched strobe
//   cpu_running_i                   core has an instruction in flight
//   cpu_exec_o, pc_wen_o, pc_o      IF enable, PC write strobe and value to core
//   core_* / pnl_*                  core and panel memory requesters
//   mem_*                           shared memory port
//   rdata_o                         read data, returned to whichever owner has rvalid
//   state_o                         STOP=0, RUN=1, STEP=2, DRAIN=3
//   halted_o, drain_err_o           sticky status flags
//   instr_cnt_o                     retired-instruction count
//
// Optional feature, enabled by defining TOY_BRKPT_EN:
//   bp_set_i, bp_addr_i, bp_pc_i    arm a PC breakpoint in STOP; PC of fetched instruction
//   bp_hit_o                        sticky breakpoint hit, cleared by the next accepted RUN
//
// state | meaning
// ------+--------------------------------------------------------------
// STOP  | core idle; panel owns memory; load/run/step accepted
// RUN   | core free-running until stop, halt or breakpoint
// STEP  | core runs until its first fetched instruction
// DRAIN | IF disabled; wait for in-flight instruction or drain timeout
module toy_run_ctrl #(
   parameter int MEM_RD_LAT = 1,
   parameter int DRAIN_TO   = 255
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        run_i,
   input  logic        stop_i,
   input  logic        step_i,
   input  logic        load_pc_i,
   input  logic [7:0]  pc_sw_i,
   input  logic        halt_i,
   input  logic        instr_val_i,
   input  logic        cpu_running_i,
   output logic        cpu_exec_o,
   output logic        pc_wen_o,
   output logic [7:0]  pc_o,
   input  logic        core_req_i,
   input  logic        core_we_i,
   input  logic [7:0]  core_addr_i,
   input  logic [15:0] core_wdata_i,
   output logic        core_gnt_o,
   output logic        core_rvalid_o,
   input  logic        pnl_req_i,
   input  logic        pnl_we_i,
   input  logic [7:0]  pnl_addr_i,
   input  logic [15:0] pnl_wdata_i,
   output logic        pnl_gnt_o,
   output logic        pnl_rvalid_o,
   output logic [15:0] rdata_o,
   output logic        mem_req_o,
   output logic        mem_we_o,
   output logic [7:0]  mem_addr_o,
   output logic [15:0] mem_wdata_o,
   input  logic [15:0] mem_rdata_i,
   output logic [1:0]  state_o,
   output logic        halted_o,
   output logic        drain_err_o,
`ifdef TOY_BRKPT_EN
   input  logic        bp_set_i,
   input  logic [7:0]  bp_addr_i,
   input  logic [7:0]  bp_pc_i,
   output logic        bp_hit_o,
`endif
   output logic [31:0] instr_cnt_o
);

   typedef enum logic [1:0] {
      ST_STOP  = 2'd0,
      ST_RUN   = 2'd1,
      ST_STEP  = 2'd2,
      ST_DRAIN = 2'd3
   } state_t;

   // Down-counter preload: terminal count 0 is reached after DRAIN_TO DRAIN cycles.
   localparam logic [7:0] DRAIN_LOAD = 8'(DRAIN_TO - 1);

   state_t                r_state;
   state_t                w_state_nxt;
   logic [7:0]            r_drain_cnt;
   logic                  r_pc_wen;
   logic [7:0]            r_pc;
   logic                  r_halted;
   logic                  r_drain_err;
   logic [31:0]           r_instr_cnt;
   logic [MEM_RD_LAT-1:0] r_rd_core;
   logic [MEM_RD_LAT-1:0] r_rd_pnl;

   logic w_exec;
   logic w_drain_to;
   logic w_load;
   logic w_run_go;
   logic w_bp_match;
   logic w_core_gnt;
   logic w_pnl_gnt;

   // Load wins over run/step in STOP, so a run in the same cycle is not accepted.
   assign w_load   = (r_state == ST_STOP) && load_pc_i;
   assign w_run_go = (r_state == ST_STOP) && !load_pc_i && run_i;

`ifdef TOY_BRKPT_EN
   logic       r_bp_armed;
   logic [7:0] r_bp_addr;
   logic       r_bp_hit;

   assign w_bp_match = (r_state == ST_RUN) && instr_val_i && r_bp_armed &&
                       (bp_pc_i == r_bp_addr);

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_bp_armed <= 1'b0;
         r_bp_addr  <= 8'd0;
         r_bp_hit   <= 1'b0;
      end else begin
         if (w_load) begin
            r_bp_armed <= 1'b0;
         end else if ((r_state == ST_STOP) && bp_set_i) begin
            r_bp_armed <= 1'b1;
            r_bp_addr  <= bp_addr_i;
         end
         if (w_bp_match) begin
            r_bp_hit <= 1'b1;
         end else if (w_run_go) begin
            r_bp_hit <= 1'b0;
         end
      end
   end

   assign bp_hit_o = r_bp_hit;
`else
   assign w_bp_match = 1'b0;
`endif

   always_comb begin
      w_state_nxt = r_state;
      w_exec      = 1'b0;
      w_drain_to  = 1'b0;
      case (r_state)
         ST_STOP: begin
            if (!load_pc_i) begin
               if (run_i) begin
                  w_state_nxt = ST_RUN;
               end else if (step_i) begin
                  w_state_nxt = ST_STEP;
               end
            end
         end
         ST_RUN: begin
            w_exec = 1'b1;
            if (stop_i || halt_i || w_bp_match) begin
               w_state_nxt = ST_DRAIN;
            end
         end
         ST_STEP: begin
            w_exec = 1'b1;
            if (stop_i || instr_val_i) begin
               w_state_nxt = ST_DRAIN;
            end
         end
         ST_DRAIN: begin
            if (!cpu_running_i) begin
               w_state_nxt = ST_STOP;
            end else if (r_drain_cnt == 8'd0) begin
               w_state_nxt = ST_STOP;
               w_drain_to  = 1'b1;
            end
         end
         default: w_state_nxt = ST_STOP;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_state     <= ST_STOP;
         r_drain_cnt <= DRAIN_LOAD;
         r_pc_wen    <= 1'b0;
         r_pc        <= 8'd0;
         r_halted    <= 1'b0;
         r_drain_err <= 1'b0;
         r_instr_cnt <= 32'd0;
         r_rd_core   <= '0;
         r_rd_pnl    <= '0;
      end else begin
         r_state     <= w_state_nxt;
         r_drain_cnt <= (r_state == ST_DRAIN) ? r_drain_cnt - 8'd1 : DRAIN_LOAD;
         r_pc_wen    <= w_load;
         if (w_load) begin
            r_pc <= pc_sw_i;
         end
         if (w_load || w_run_go) begin
            r_halted <= 1'b0;
         end else if ((r_state == ST_RUN) && halt_i) begin
            r_halted <= 1'b1;
         end
         if (w_drain_to) begin
            r_drain_err <= 1'b1;
         end
         if (w_load) begin
            r_instr_cnt <= 32'd0;
         end else if (instr_val_i && (r_state != ST_STOP)) begin
            r_instr_cnt <= r_instr_cnt + 32'd1;
         end
         // Owner tags travel with each read so returns survive state changes.
         r_rd_core <= (r_rd_core << 1) | MEM_RD_LAT'(w_core_gnt && !core_we_i);
         r_rd_pnl  <= (r_rd_pnl  << 1) | MEM_RD_LAT'(w_pnl_gnt  && !pnl_we_i);
      end
   end

   // Outside STOP the core owns memory. In STOP the core is still served while
   // cpu_running_i is high so residual traffic after a forced drain completes.
   assign w_core_gnt = core_req_i && ((r_state != ST_STOP) || cpu_running_i);
   assign w_pnl_gnt  = (r_state == ST_STOP) && pnl_req_i && !w_core_gnt;

   assign core_gnt_o  = w_core_gnt;
   assign pnl_gnt_o   = w_pnl_gnt;
   assign mem_req_o   = w_core_gnt || w_pnl_gnt;
   assign mem_we_o    = w_core_gnt ? core_we_i    : (w_pnl_gnt ? pnl_we_i    : 1'b0);
   assign mem_addr_o  = w_core_gnt ? core_addr_i  : (w_pnl_gnt ? pnl_addr_i  : 8'd0);
   assign mem_wdata_o = w_core_gnt ? core_wdata_i : (w_pnl_gnt ? pnl_wdata_i : 16'd0);

   assign core_rvalid_o = r_rd_core[MEM_RD_LAT-1];
   assign pnl_rvalid_o  = r_rd_pnl[MEM_RD_LAT-1];
   assign rdata_o       = (core_rvalid_o || pnl_rvalid_o) ? mem_rdata_i : 16'd0;

   assign cpu_exec_o  = w_exec;
   assign pc_wen_o    = r_pc_wen;
   assign pc_o        = r_pc;
   assign state_o     = r_state;
   assign halted_o    = r_halted;
   assign drain_err_o = r_drain_err;
   assign instr_cnt_o = r_instr_cnt;

endmodule
